toeplitz_ctrl: RTL
==================

# toeplitz_ctrl

Sequencer for the Toeplitz-hash datapath. It loads the column seed and the reversed-row seed over a word stream, replacing the simulation-only memory-file load. It then consumes N-bit input blocks as BS-bit words and runs the bit-serial Toeplitz multiply, one input bit per cycle. It emits each L-bit hash on a valid/ready output and sits between the raw-key buffer and the hash sink.

## Interface
Parameters:
- BS, 64, stream word width in bits.
- N, 256, input block length (Toeplitz columns); must be a multiple of BS.
- L, 128, hash length (Toeplitz rows); must be a multiple of BS.
- Derived: XSZ = N/BS (row/input words), YSZ = L/BS (column words).

Ports:
- clk  in  1  sole clock, all state on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- seed_valid  in  1  seed word present.
- seed_ready  out  1  seed word accepted when both high.
- seed_data  in  BS  seed word.
- in_valid  in  1  input word present.
- in_ready  out  1  input word accepted when both high.
- in_data  in  BS  input word; MSB is the earliest bit.
- out_valid  out  1  hash present.
- out_ready  in  1  hash consumed when both high.
- out_data  out  L  hash value.
- seeded  out  1  a complete seed is held.
- busy  out  1  high in SHIFT or OUT.

## Operation
- States:
  - LOAD: seed_ready=1. Accept YSZ column words, then XSZ reversed-row words.
    - Word 0 of each group fills the most-significant BS bits of its seed register.
    - After the final word: seeded=1 and the state moves to WAIT.
  - WAIT: in_ready=1. On handshake, latch in_data into the shift word and go to SHIFT.
  - SHIFT: BS cycles, one input bit per cycle, MSB first.
    - After the XSZ-th word, go to OUT.
    - Otherwise return to WAIT.
  - OUT: out_valid=1 and out_data=acc. On out_ready, go to WAIT and reinitialise.
- Reinitialise: acc=0, g=col_seed, r=row_seed>>1. Applies on seed completion and after each hash handoff. Bit 0 of the row is shared with the column and is skipped.
- Per SHIFT cycle, with x = current input bit:
  - acc ^= x ? g : 0
  - g <= (g>>1) | (r[0]<<(L-1))
  - r <= r>>1
- Counters:
  - seed word counter 0..XSZ+YSZ-1
  - input word counter 0..XSZ-1
  - bit counter 0..BS-1
  - All counters wrap to 0 at their terminal value.
- Width rule: all XOR arithmetic is GF(2), L bits wide. There is no carry.
- seed_ready=0 outside LOAD. in_ready=0 outside WAIT.
- out_data holds acc stably while out_valid=1 and out_ready=0.

## Timing
- Reset values:
  - outputs: seed_ready=1, in_ready=0, out_valid=0, out_data=0, seeded=0, busy=0.
  - internal: state LOAD, all counters 0, all registers 0.
- rstn assertion at any point, including mid-SHIFT or in OUT, returns every element immediately to its reset value. The partial hash is discarded and the seed must be reloaded.
- Seed load: one word per cycle at full throughput. seeded rises the cycle after the last seed handshake.
- Per word:
  - 1 cycle for the WAIT handshake, then BS SHIFT cycles.
  - in_ready reasserts the cycle after the last SHIFT cycle.
- Hash latency: out_valid rises the cycle after the final SHIFT cycle of word XSZ-1.
- Block period: XSZ·(BS+1)+1 cycles minimum, with in_valid and out_ready held high.
- out_ready high in OUT: in_ready=1 on the following cycle.
- in_valid deasserted mid-block: the controller waits in WAIT indefinitely and the accumulator is preserved.

## Configuration
- TOEPLITZ_RESEED_EN defined:
  - In WAIT with input word counter = 0, seed_ready=1 as well.
  - A seed handshake takes priority over a simultaneous input handshake: the input word is not accepted that cycle.
  - The handshake clears seeded, enters LOAD with the first word already counted, and the full new seed must then complete.
- TOEPLITZ_RESEED_EN undefined:
  - The seed loads once after reset. seed_ready stays 0 until the next rstn assertion.
  - Re-seeding requires reset.

## Test plan
Directed scenarios use BS=4, N=8, L=4 and column seed 4'hA.
- Seed col=4'hA, rrow=8'h02; input words 4'h8, 4'h0 (only bit j=0 set) -> out_data=4'hA.
- Same seed; input words 4'h4, 4'h0 (only bit j=1 set) -> out_data=4'hD.
- Linearity check:
  - Run blocks {4'h8,4'h0}, {4'h4,4'h0}, {4'hC,4'h0}.
  - Required: third hash = 4'hA ^ 4'hD = 4'h7.
  - Required: each block takes exactly 2·5+1 cycles with valid/ready held high.
- Backpressure: hold out_ready=0 for 5 cycles in OUT.
  - out_data is stable and in_ready=0.
  - A second block starts only after the handshake.
- Reset mid-SHIFT on word 1 -> all reset values; seeded=0; seed_ready=1 the cycle after rstn deasserts.
- With TOEPLITZ_RESEED_EN: after one block, load col=4'h5, rrow=8'h00, then input {4'h8,4'h0} -> 4'h5. Without the macro, seed_ready=0 throughout after the first load.

Source files
------------

// File: rtl/toeplitz_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | toeplitz_ctrl : seed loader and bit-serial Toeplitz-hash sequencer.       |
// | Optional macro TOEPLITZ_RESEED_EN allows re-seeding between blocks.       |
// | Revision 1.0 - initial release                                            |
// +--------------------------------------------------------------------------+
module toeplitz_ctrl #(
  parameter int BS = 64,
  parameter int N  = 256,
  parameter int L  = 128
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          seed_valid,
  output logic          seed_ready,
  input  logic [BS-1:0] seed_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BS-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [L-1:0]  out_data,
  output logic          seeded,
  output logic          busy
);
  localparam int XSZ = N / BS;
  localparam int YSZ = L / BS;
  localparam int SW  = $clog2(XSZ + YSZ);
  localparam int IW  = (XSZ > 1) ? $clog2(XSZ) : 1;
  localparam int BW  = (BS > 1) ? $clog2(BS) : 1;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] seed_cnt_q, seed_cnt_d;
  logic [IW-1:0] in_cnt_q, in_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [L-1:0]  col_q, col_d, g_q, g_d, acc_q, acc_d;
  logic [N-1:0]  row_q, row_d, r_q, r_d;
  logic [BS-1:0] shw_q, shw_d;
  logic          seeded_q, seeded_d;
  logic          seed_fire, in_fire;

  always_comb begin
    seed_ready = (state_q == ST_LOAD);
`ifdef TOEPLITZ_RESEED_EN
    if (state_q == ST_WAIT && in_cnt_q == '0) seed_ready = 1'b1;
`endif
  end

  assign in_ready  = (state_q == ST_WAIT);
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = out_valid ? acc_q : '0;
  assign seeded    = seeded_q;
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_OUT);
  // A seed word wins over a same-cycle input word.
  assign seed_fire = seed_valid && seed_ready;
  assign in_fire   = in_valid && in_ready && !seed_fire;

  always_comb begin
    state_d    = state_q;
    seed_cnt_d = seed_cnt_q;
    in_cnt_d   = in_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    g_d        = g_q;
    r_d        = r_q;
    acc_d      = acc_q;
    shw_d      = shw_q;
    seeded_d   = seeded_q;

    if (seed_fire) begin
      // Words shift in from the bottom so word 0 ends up in the MSBs.
      if (seed_cnt_q < SW'(YSZ)) col_d = (col_q << BS) | L'(seed_data);
      else                       row_d = (row_q << BS) | N'(seed_data);
      if (seed_cnt_q == SW'(XSZ + YSZ - 1)) begin
        seed_cnt_d = '0;
        seeded_d   = 1'b1;
        state_d    = ST_WAIT;
        in_cnt_d   = '0;
        bit_cnt_d  = '0;
        acc_d      = '0;
        g_d        = col_d;
        r_d        = row_d >> 1;
      end else begin
        seed_cnt_d = seed_cnt_q + SW'(1);
        seeded_d   = 1'b0;
        state_d    = ST_LOAD;
      end
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (in_fire) begin
            shw_d     = in_data;
            bit_cnt_d = '0;
            state_d   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (shw_q[BS-1]) acc_d = acc_q ^ g_q;
          g_d   = {r_q[0], g_q[L-1:1]};
          r_d   = r_q >> 1;
          shw_d = shw_q << 1;
          if (bit_cnt_q == BW'(BS - 1)) begin
            bit_cnt_d = '0;
            if (in_cnt_q == IW'(XSZ - 1)) begin
              in_cnt_d = '0;
              state_d  = ST_OUT;
            end else begin
              in_cnt_d = in_cnt_q + IW'(1);
              state_d  = ST_WAIT;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state_d = ST_WAIT;
            acc_d   = '0;
            g_d     = col_q;
            r_d     = row_q >> 1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_LOAD;
      seed_cnt_q <= '0;
      in_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      g_q        <= '0;
      r_q        <= '0;
      acc_q      <= '0;
      shw_q      <= '0;
      seeded_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_cnt_q <= seed_cnt_d;
      in_cnt_q   <= in_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      g_q        <= g_d;
      r_q        <= r_d;
      acc_q      <= acc_d;
      shw_q      <= shw_d;
      seeded_q   <= seeded_d;
    end
  end
endmodule
`default_nettype wire
